// File: rtl/clint_regslave.sv
// clint_regslave: core-local interruptor as a register-bus slave.
//   Free-running 64-bit mtime (advanced once every PRESCALE cycles), one
//   64-bit mtimecmp and one msip bit per hart. Read data is registered
//   one cycle after a read strobe; interrupt outputs are registered.
// Ports:
//   clk_i, rst_i           clock, synchronous active-low reset
//   en_i, we_i             access strobe, 1 = write / 0 = read
//   addr_i                 byte address, only [15:3] decoded
//   be_i, wdata_i          byte enables and write data
//   rdata_o                registered read data
//   timer_irq_o            per-hart machine timer interrupt
//   soft_irq_o             per-hart machine software interrupt
module clint_regslave #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_HARTS  = 1,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [NUM_HARTS-1:0]    timer_irq_o,
  output logic [NUM_HARTS-1:0]    soft_irq_o
);

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("clint_regslave: DATA_WIDTH must be 64");
  end
  if (NUM_HARTS < 1 || NUM_HARTS > 32) begin : g_bad_num_harts
    $error("clint_regslave: NUM_HARTS must be in 1..32");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("clint_regslave: PRESCALE must be >= 1");
  end

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [12:0] CMP_BASE = 13'h0800;  // 0x4000 >> 3
  localparam logic [12:0] MTIME_W  = 13'h17FF;  // 0xBFF8 >> 3

  logic [PS_W-1:0] ps_cnt;
  logic            tick;
  logic [12:0]     word;
  logic            wr;
  logic            rd;
  logic [63:0]     mtime;
  logic [63:0]     mtime_inc;
  logic [63:0]     mtime_nxt;
  logic [63:0]     rd_val;
  logic [63:0]     mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;
  logic            unused_addr;

  assign tick        = (ps_cnt == PS_W'(PRESCALE - 1));
  assign word        = addr_i[15:3];
  assign wr          = en_i & we_i;
  assign rd          = en_i & ~we_i;
  assign unused_addr = ^{addr_i[ADDR_WIDTH-1:16], addr_i[2:0]};

  // Write bytes are overlaid on the already-incremented value, so a
  // written byte never sees a carry from the increment.
  always_comb begin
    mtime_inc = tick ? mtime + 64'd1 : mtime;
    mtime_nxt = mtime_inc;
    if (wr && word == MTIME_W) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (be_i[b]) mtime_nxt[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  // Read decode: MSIP word W packs harts 2W (bit 0) and 2W+1 (bit 32).
  always_comb begin
    rd_val = '0;
    if (word < CMP_BASE) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (word == 13'(h / 2)) begin
          if (h % 2 == 0) rd_val[0]  = msip[h];
          else            rd_val[32] = msip[h];
        end
      end
    end else if (word == MTIME_W) begin
      rd_val = mtime;
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (word == CMP_BASE + 13'(h)) rd_val = mtimecmp[h];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ps_cnt      <= '0;
      mtime       <= '0;
      msip        <= '0;
      rdata_o     <= '0;
      timer_irq_o <= '0;
      soft_irq_o  <= '0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        mtimecmp[h] <= '1;
      end
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      mtime  <= mtime_nxt;
      if (rd) rdata_o <= rd_val;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (wr && word == CMP_BASE + 13'(h)) begin
          for (int unsigned b = 0; b < 8; b++) begin
            if (be_i[b]) mtimecmp[h][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
        if (wr && word == 13'(h / 2)) begin
          if (h % 2 == 0) begin
            if (be_i[0]) msip[h] <= wdata_i[0];
          end else begin
            if (be_i[4]) msip[h] <= wdata_i[32];
          end
        end
        timer_irq_o[h] <= (mtime >= mtimecmp[h]);
      end
      soft_irq_o <= msip;
    end
  end

endmodule

// File: tb/tb_clint_regslave.sv
// tb_clint_regslave: directed bench for clint_regslave.
//   dut_a: NUM_HARTS=2, PRESCALE=1 (main checks)
//   dut_b: NUM_HARTS=1, PRESCALE=4 (reset and prescaled counting)
module tb_clint_regslave;

  logic        clk;
  logic        rst;
  logic        en;
  logic        we;
  logic [63:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic [63:0] rdata_a;
  logic [1:0]  timer_a;
  logic [1:0]  soft_a;
  logic [63:0] rdata_b;
  logic [0:0]  timer_b;
  logic [0:0]  soft_b;

  int unsigned errors;
  int unsigned checks;
  int unsigned n_edges;

  clint_regslave #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .NUM_HARTS(2), .PRESCALE(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .rdata_o(rdata_a), .timer_irq_o(timer_a), .soft_irq_o(soft_a)
  );

  clint_regslave #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .NUM_HARTS(1), .PRESCALE(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .rdata_o(rdata_b), .timer_irq_o(timer_b), .soft_irq_o(soft_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        chk_rd;
    logic [63:0] exp_rd;
    logic [1:0]  exp_soft;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One rising edge; mtime in dut_a counts edges seen with reset released.
  task automatic step();
    @(posedge clk);
    if (rst) n_edges++;
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [15:0] a,
                       input logic [7:0] b, input logic [63:0] d);
    en    = e;
    we    = w;
    addr  = {48'h0, a};
    be    = b;
    wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 8'h0, 64'h0);
  endtask

  logic [63:0] exp_t;
  logic [63:0] r1;

  initial begin
    errors  = 0;
    checks  = 0;
    n_edges = 0;
    rst     = 1'b0;
    idle();

    //                 we    addr      be     wdata                   chk   exp_rd                  soft
    vecs[0]  = '{1'b1, 16'h0000, 8'hFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0,                  2'b11};
    vecs[1]  = '{1'b1, 16'h0000, 8'h01, 64'h0,                   1'b0, 64'h0,                  2'b10};
    vecs[2]  = '{1'b0, 16'h0000, 8'hFF, 64'h0,                   1'b1, 64'h0000_0001_0000_0000, 2'b10};
    vecs[3]  = '{1'b0, 16'h8000, 8'hFF, 64'h0,                   1'b1, 64'h0,                  2'b10};
    vecs[4]  = '{1'b0, 16'h0004, 8'h00, 64'h0,                   1'b1, 64'h0000_0001_0000_0000, 2'b10};
    vecs[5]  = '{1'b1, 16'h0008, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0,                  2'b10};
    vecs[6]  = '{1'b0, 16'h0008, 8'hFF, 64'h0,                   1'b1, 64'h0,                  2'b10};
    vecs[7]  = '{1'b1, 16'h4000, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0,                  2'b10};
    vecs[8]  = '{1'b0, 16'h4000, 8'hFF, 64'h0,                   1'b1, 64'h0123_4567_89AB_CDEF, 2'b10};
    vecs[9]  = '{1'b1, 16'h4000, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0,                  2'b10};
    vecs[10] = '{1'b0, 16'h4000, 8'hFF, 64'h0,                   1'b1, 64'h0123_4567_FFFF_FFFF, 2'b10};
    vecs[11] = '{1'b1, 16'h4010, 8'hFF, 64'h5,                   1'b0, 64'h0,                  2'b10};
    vecs[12] = '{1'b0, 16'h4010, 8'hFF, 64'h0,                   1'b1, 64'h0,                  2'b10};
    vecs[13] = '{1'b1, 16'h4000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0,                  2'b10};
    vecs[14] = '{1'b0, 16'h4000, 8'hFF, 64'h0,                   1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10};
    vecs[15] = '{1'b1, 16'h0000, 8'h10, 64'h0,                   1'b0, 64'h0,                  2'b00};
    vecs[16] = '{1'b1, 16'h0000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0,                  2'b11};
    vecs[17] = '{1'b0, 16'h0000, 8'hFF, 64'h0,                   1'b1, 64'h0000_0001_0000_0001, 2'b11};
    vecs[18] = '{1'b0, 16'hBFF0, 8'hFF, 64'h0,                   1'b1, 64'h0,                  2'b11};

    // Reset held for 3 cycles
    repeat (3) step();
    check("rst_rdata_a", rdata_a, 64'h0);
    check("rst_timer_a", {62'h0, timer_a}, 64'h0);
    check("rst_soft_a",  {62'h0, soft_a}, 64'h0);
    check("rst_rdata_b", rdata_b, 64'h0);
    check("rst_timer_b", {63'h0, timer_b}, 64'h0);
    check("rst_soft_b",  {63'h0, soft_b}, 64'h0);

    // First read in the release cycle sees mtime = 0
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'hBFF8, 8'hFF, 64'h0);
    step();
    check("first_mtime_a", rdata_a, 64'h0);
    check("first_mtime_b", rdata_b, 64'h0);
    drive(1'b1, 1'b0, 16'h4000, 8'hFF, 64'h0);
    step();
    check("rst_cmp_a", rdata_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_cmp_b", rdata_b, 64'hFFFF_FFFF_FFFF_FFFF);

    // Counting
    idle();
    repeat (10) step();
    drive(1'b1, 1'b0, 16'hBFF8, 8'hFF, 64'h0);
    exp_t = 64'(n_edges);
    step();
    check("count_p1", rdata_a, exp_t);
    check("count_p4", rdata_b, exp_t / 4);
    r1 = rdata_b;
    idle();
    repeat (15) step();
    check("rdata_hold_idle", rdata_a, exp_t);
    drive(1'b1, 1'b0, 16'hBFF8, 8'hFF, 64'h0);
    exp_t = 64'(n_edges);
    step();
    check("count_p1_b", rdata_a, exp_t);
    check("count_p4_b", rdata_b, exp_t / 4);
    check("p4_delta16", rdata_b - r1, 64'd4);

    // Register table
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      step();
      idle();
      step();
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata_a, vecs[i].exp_rd);
      check($sformatf("vec%0d_soft", i), {62'h0, soft_a}, {62'h0, vecs[i].exp_soft});
    end

    // Byte-enable write to mtime while it increments
    drive(1'b1, 1'b1, 16'hBFF8, 8'hFF, 64'hFF);
    step();
    idle();
    step();
    drive(1'b1, 1'b1, 16'hBFF8, 8'h0F, 64'h1122_3344_5566_7788);
    step();
    drive(1'b1, 1'b0, 16'hBFF8, 8'hFF, 64'h0);
    step();
    check("mtime_be0f", rdata_a, 64'h0000_0000_5566_7788);

    drive(1'b1, 1'b1, 16'hBFF8, 8'hFF, 64'h0000_0000_FFFF_FFFF);
    step();
    drive(1'b1, 1'b1, 16'hBFF8, 8'h0F, 64'h0);
    step();
    drive(1'b1, 1'b0, 16'hBFF8, 8'hFF, 64'h0);
    step();
    check("mtime_carry_upper", rdata_a, 64'h0000_0001_0000_0000);

    drive(1'b1, 1'b1, 16'hBFF8, 8'hFF, 64'h0000_0000_FFFF_FFFF);
    step();
    drive(1'b1, 1'b1, 16'hBFF8, 8'hF0, 64'h0);
    step();
    drive(1'b1, 1'b0, 16'hBFF8, 8'hFF, 64'h0);
    step();
    check("mtime_no_carry_written", rdata_a, 64'h0);

    // Wrap at 2^64-1, back-to-back reads, hold on write
    drive(1'b1, 1'b1, 16'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    drive(1'b1, 1'b0, 16'hBFF8, 8'hFF, 64'h0);
    step();
    check("mtime_max", rdata_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check("timer_at_max", {62'h0, timer_a}, 64'h3);
    drive(1'b1, 1'b1, 16'h8000, 8'hFF, 64'h1234);
    step();
    check("rdata_hold_write", rdata_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check("timer_after_wrap", {62'h0, timer_a}, 64'h0);
    drive(1'b1, 1'b0, 16'hBFF8, 8'hFF, 64'h0);
    step();
    check("mtime_wrapped", rdata_a, 64'h1);

    // Timer interrupt on hart 1
    drive(1'b1, 1'b1, 16'h4008, 8'hFF, 64'd50);
    step();
    drive(1'b1, 1'b1, 16'hBFF8, 8'hFF, 64'h0);
    step();
    idle();
    repeat (49) step();
    step();
    check("timer_before_50", {62'h0, timer_a}, 64'h0);
    step();
    check("timer_at_50", {62'h0, timer_a}, 64'h2);
    drive(1'b1, 1'b1, 16'h4008, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("timer_clear_edge1", {62'h0, timer_a}, 64'h2);
    idle();
    step();
    check("timer_clear_edge2", {62'h0, timer_a}, 64'h0);

    // Reset drops a simultaneous write
    drive(1'b1, 1'b1, 16'h4008, 8'hFF, 64'h0);
    rst = 1'b0;
    step();
    check("midrst_soft", {62'h0, soft_a}, 64'h0);
    check("midrst_rdata", rdata_a, 64'h0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h4008, 8'hFF, 64'h0);
    step();
    check("midrst_cmp_dropped", rdata_a, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b1, 1'b0, 16'h0000, 8'hFF, 64'h0);
    step();
    check("midrst_msip", rdata_a, 64'h0);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
